// File: rtl/even_parity_checker_pkg.sv
// Shared definitions for the even-parity checker.
//   DATA_W      : data nibble width (a, b, c, d)
//   DEF_CNT_W   : default width of the optional error counter
//   parity5()   : XOR of five bits; 1 means an odd number of ones
package even_parity_checker_pkg;

    localparam int DATA_W    = 4;
    localparam int DEF_CNT_W = 8;

    function automatic logic parity5(input logic b4, input logic b3,
                                     input logic b2, input logic b1,
                                     input logic b0);
        return b4 ^ b3 ^ b2 ^ b1 ^ b0;
    endfunction

endpackage

// File: rtl/epc_err_counter.sv
// Saturating error counter for link-health monitoring.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset (count -> 0)
//   i_inc  : an error was seen this cycle
//   i_clr  : clear the count; a simultaneous i_inc loads 1 instead of 0
//   o_cnt  : current count, sticks at all-ones instead of wrapping
module epc_err_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? W'(1) : '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/even_parity_checker.sv
// Registered even-parity checker for a nibble link receiver.
// Build option: define EPC_ERR_COUNT_EN to add the err_cnt port and its
// saturating counter; without it the port and counter do not exist.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : a, b, c, d, p carry a word to check this cycle
//   a, b, c, d  : data nibble, a is the MSB
//   p           : received even-parity bit
//   clr_err     : clears sticky_err (and err_cnt); a same-cycle error wins
//   pec         : 1 = parity error on the last checked word (held when idle)
//   out_valid   : pec was updated by the previous edge
//   sticky_err  : set on any error, held until cleared
//   err_cnt     : saturating error count (EPC_ERR_COUNT_EN only)
module even_parity_checker
    import even_parity_checker_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             p,
    input  logic             clr_err,
    output logic             pec,
    output logic             out_valid,
`ifdef EPC_ERR_COUNT_EN
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             sticky_err
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [DATA_W-1:0] w_data;
    logic              w_pec_next;
    logic              w_err;

    logic              r_pec;
    logic              r_out_valid;
    logic              r_sticky;

    assign w_data     = {a, b, c, d};
    assign w_pec_next = parity5(w_data[3], w_data[2], w_data[1], w_data[0], p);
    assign w_err      = in_valid & w_pec_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pec       <= 1'b0;
            r_out_valid <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_pec <= w_pec_next;
            end
            // Set has priority over clear so an error in the clearing cycle is not lost.
            if (w_err) begin
                r_sticky <= 1'b1;
            end else if (clr_err) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign pec        = r_pec;
    assign out_valid  = r_out_valid;
    assign sticky_err = r_sticky;

`ifdef EPC_ERR_COUNT_EN
    epc_err_counter #(
        .W (CNT_W)
    ) u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_err),
        .i_clr (clr_err),
        .o_cnt (err_cnt)
    );
`endif

endmodule

// File: tb/tb_even_parity_checker.sv
// Self-checking bench for even_parity_checker: directed vectors, a
// specification-level reference model compared on every falling edge, and
// literal expectations at key points.
module tb_even_parity_checker;

`ifdef EPC_ERR_COUNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 8;
`endif
    localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, in_valid, a, b, c, d, p, clr_err;
    logic pec, out_valid, sticky_err;
    logic [TB_CNT_W-1:0] err_cnt_w;

    int checks = 0;
    int errors = 0;

    even_parity_checker #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .p          (p),
        .clr_err    (clr_err),
        .pec        (pec),
        .out_valid  (out_valid),
`ifdef EPC_ERR_COUNT_EN
        .err_cnt    (err_cnt_w),
`endif
        .sticky_err (sticky_err)
    );

`ifndef EPC_ERR_COUNT_EN
    assign err_cnt_w = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: parity from the count of ones, counter as a clamped integer.
    logic m_ok = 1'b0;
    int   m_pec, m_ov, m_sticky, m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1;
            m_pec = 0; m_ov = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            int ones;
            bit err;
            ones = $countones({a, b, c, d, p});
            err  = in_valid && (ones % 2 == 1);
            m_ov = in_valid ? 1 : 0;
            if (in_valid) m_pec = ones % 2;
            if (err) begin
                m_sticky = 1;
                m_cnt = clr_err ? 1 : ((m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1);
            end else if (clr_err) begin
                m_sticky = 0;
                m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("model_pec", int'(pec), m_pec);
            check("model_out_valid", int'(out_valid), m_ov);
            check("model_sticky", int'(sticky_err), m_sticky);
`ifdef EPC_ERR_COUNT_EN
            check("model_err_cnt", int'(err_cnt_w), m_cnt);
`endif
        end
    end

    // Drive one cycle of inputs, then return just after the capturing edge.
    task automatic cyc(input logic [4:0] w, input logic v, input logic cl, input logic r);
        {a, b, c, d, p} = w;
        in_valid = v;
        clr_err  = cl;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a, b, c, d, p} = 5'b0;
        in_valid = 1'b0;
        clr_err  = 1'b0;
        rst      = 1'b1;

        // 1. Reset then idle
        cyc(5'b00000, 1'b0, 1'b0, 1'b1);
        cyc(5'b00000, 1'b0, 1'b0, 1'b1);
        cyc(5'b00000, 1'b0, 1'b0, 1'b0);
        check("reset_pec", int'(pec), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_sticky", int'(sticky_err), 0);
`ifdef EPC_ERR_COUNT_EN
        check("reset_err_cnt", int'(err_cnt_w), 0);
`endif

        // 2. Exhaustive sweep of {a,b,c,d,p}
        for (int i = 0; i < 32; i++) begin
            cyc(5'(i), 1'b1, 1'b0, 1'b0);
            check("sweep_out_valid", int'(out_valid), 1);
            case (i)
                5'b00000: check("sweep_00000", int'(pec), 0);
                5'b01000: check("sweep_01000", int'(pec), 1);
                5'b01001: check("sweep_01001", int'(pec), 0);
                5'b11111: check("sweep_11111", int'(pec), 1);
                default: ;
            endcase
        end

        // 3. Sticky and clear
        cyc(5'b00000, 1'b1, 1'b1, 1'b0);
        check("clr_before_sticky", int'(sticky_err), 0);
        cyc(5'b01000, 1'b1, 1'b0, 1'b0);
        check("sticky_set", int'(sticky_err), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b00000, 1'b1, 1'b0, 1'b0);
            check("sticky_hold", int'(sticky_err), 1);
        end
        cyc(5'b00000, 1'b1, 1'b1, 1'b0);
        check("sticky_cleared", int'(sticky_err), 0);
        cyc(5'b01000, 1'b1, 1'b1, 1'b0);
        check("sticky_set_wins", int'(sticky_err), 1);
`ifdef EPC_ERR_COUNT_EN
        check("cnt_set_wins", int'(err_cnt_w), 1);

        // 4. Counter saturation (CNT_W = 2)
        cyc(5'b00000, 1'b1, 1'b1, 1'b0);
        check("cnt_cleared", int'(err_cnt_w), 0);
        for (int i = 0; i < 5; i++) begin
            int exp_cnt;
            exp_cnt = (i < 3) ? i + 1 : 3;
            cyc(5'b00100, 1'b1, 1'b0, 1'b0);
            check("cnt_saturate", int'(err_cnt_w), exp_cnt);
        end
`endif

        // 5. Mid-stream reset
        cyc(5'b01000, 1'b1, 1'b0, 1'b0);
        cyc(5'b00010, 1'b1, 1'b0, 1'b0);
        cyc(5'b01000, 1'b1, 1'b0, 1'b1);
        check("midrst_pec", int'(pec), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_sticky", int'(sticky_err), 0);
`ifdef EPC_ERR_COUNT_EN
        check("midrst_err_cnt", int'(err_cnt_w), 0);
`endif

        // 6. in_valid gating
        cyc(5'b01000, 1'b1, 1'b0, 1'b0);
        cyc(5'b00000, 1'b1, 1'b0, 1'b0);
        check("gate_pre_pec", int'(pec), 0);
        cyc(5'b10000, 1'b0, 1'b0, 1'b0);
        check("gate_pec_held", int'(pec), 0);
        check("gate_out_valid", int'(out_valid), 0);
        check("gate_sticky", int'(sticky_err), 1);
`ifdef EPC_ERR_COUNT_EN
        check("gate_err_cnt", int'(err_cnt_w), 1);
`endif
        cyc(5'b00000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/even_parity_checker.md
Name: even_parity_checker

Overview:
Registered even-parity checker for a 4-bit data nibble (a, b, c, d) plus its parity bit p. The block flags an error when the five bits together carry an odd number of ones. It sits at the receive side of a nibble link, downstream of the sender's even-parity generator. It also provides a sticky error flag and, optionally, a saturating error counter for link-health monitoring.

Parameters:
CNT_W, 8, width of the error counter (err_cnt); only meaningful when EPC_ERR_COUNT_EN is defined.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  a, b, c, d, p hold a word to be checked this cycle
a  input  1  data bit 3 (MSB)
b  input  1  data bit 2
c  input  1  data bit 1
d  input  1  data bit 0 (LSB)
p  input  1  received even-parity bit
clr_err  input  1  clears sticky_err (and err_cnt when present)
pec  output  1  parity-check result: 1 = parity error (odd ones count), 0 = OK
out_valid  output  1  pec is valid this cycle
sticky_err  output  1  set on any flagged error; held until cleared
err_cnt  output  CNT_W  saturating error count (only with EPC_ERR_COUNT_EN)

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset: pec=0, out_valid=0, sticky_err=0, err_cnt=0. Reset takes priority over all other inputs.
- Check function: pec_next = a ^ b ^ c ^ d ^ p.
  - Even number of ones among the five bits -> 0 (no error).
  - Odd number -> 1 (error).
  - Examples: all zero -> 0; b=1 only -> 1; a=b=c=d=p=1 -> 1; a=b=1 -> 0.
- Latency: 1 cycle. When in_valid=1 at edge N, then from edge N through edge N+1: pec=pec_next and out_valid=1.
- When in_valid=0 at an edge: out_valid goes to 0 and pec holds its last value.
- No back-pressure. A new word can be accepted every cycle.
- sticky_err:
  - Set at the edge where in_valid=1 and pec_next=1.
  - Cleared at an edge where clr_err=1.
  - If clr_err=1 and a new error arrive at the same edge, set wins and sticky_err=1.
- err_cnt (feature on):
  - Increments by 1 at each edge with in_valid=1 and pec_next=1.
  - Saturates at 2^CNT_W-1; it never wraps.
  - clr_err=1 loads 0, unless an error arrives at the same edge, in which case it loads 1.
- Inputs are treated as synchronous to clk. No internal synchronizers.

Optional Feature:
- Macro: EPC_ERR_COUNT_EN.
- Defined: err_cnt port and the saturating counter exist as described in Behaviour.
- Undefined: err_cnt port and counter are absent. All other ports and behaviour are unchanged.

Decomposition:
- Package even_parity_checker_pkg holds:
  - DATA_W = 4;
  - default CNT_W = 8;
  - a function parity5 returning the XOR of five bits.
- One sub-module: epc_err_counter, a saturating counter with increment/clear inputs and the set-wins rule. It is instantiated only under EPC_ERR_COUNT_EN.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then rst=0 with in_valid=0 -> pec=0, out_valid=0, sticky_err=0, err_cnt=0.
2. Exhaustive sweep: in_valid=1, step {a,b,c,d,p} through all 32 values, one per cycle -> each pec equals the XOR of that word one cycle later (00000->0, 01000->1, 01001->0, 11111->1), with out_valid=1 throughout.
3. Sticky and clear: inject 01000 once, then 00000 for 3 cycles -> sticky_err stays 1. Pulse clr_err -> sticky_err=0 the next cycle. Assert clr_err together with an error word -> sticky_err=1.
4. Counter saturation with CNT_W=2 and EPC_ERR_COUNT_EN: apply 5 consecutive error words -> err_cnt goes 1, 2, 3, 3, 3.
5. Mid-stream reset: stream error words, then assert rst for 1 cycle while in_valid=1 -> the next cycle shows pec=0, out_valid=0, sticky_err=0, err_cnt=0.
6. in_valid gating: apply error word 10000 with in_valid=0 -> pec, sticky_err and err_cnt all unchanged, and out_valid=0.
